// File: rtl/decim4x.sv
// decim4x: 4:1 boxcar decimator (4-tap moving sum scaled by 1/4) with phase checking.
// Ports:
//   clock    - master clock, rising edge
//   reset    - asynchronous, active-low reset
//   clkenin  - 4xFs input sample strobe (one-cycle pulse)
//   clkenout - Fs output strobe (one-cycle pulse)
//   xkin     - signed input sample, valid when clkenin=1
//   ykout    - signed decimated output, registered
//   ykvalid  - one-cycle pulse marking a new ykout
//   phaseerr - sticky flag: clkenout did not follow exactly four clkenin pulses
// Build option: define DECIM4X_ROUND_EN for round-half-up scaling; default truncates.
module decim4x #(
    parameter int WIDTH = 18
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clkenin,
    input  logic                    clkenout,
    input  logic signed [WIDTH-1:0] xkin,
    output logic signed [WIDTH-1:0] ykout,
    output logic                    ykvalid,
    output logic                    phaseerr
);
    localparam int SW = WIDTH + 2;

    logic signed [WIDTH-1:0] d0, d1, d2, d3;
    logic signed [SW-1:0]    s, s_adj;
    logic [2:0]              phase, phase_now;
    logic                    started;

    always_comb begin
        // A coincident sample replaces the oldest tap so it joins this output's window;
        // when clkenout is low the sum is unused, so clkenin alone may select xkin.
        s = SW'(clkenin ? xkin : d3) + SW'(d0) + SW'(d1) + SW'(d2);
`ifdef DECIM4X_ROUND_EN
        s_adj = s + SW'(2);
`else
        s_adj = s;
`endif
        phase_now = (clkenin && phase != 3'd7) ? phase + 3'd1 : phase;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d0       <= '0;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            ykout    <= '0;
            ykvalid  <= 1'b0;
            phaseerr <= 1'b0;
            phase    <= '0;
            started  <= 1'b0;
        end else begin
            if (clkenin) begin
                d0 <= xkin;
                d1 <= d0;
                d2 <= d1;
                d3 <= d2;
            end
            ykvalid <= clkenout;
            if (clkenout) begin
                // Arithmetic shift by 2 is the bit slice of the two's complement sum.
                ykout   <= s_adj[WIDTH+1:2];
                phase   <= '0;
                started <= 1'b1;
                if (started && phase_now != 3'd4)
                    phaseerr <= 1'b1;
            end else begin
                phase <= phase_now;
            end
        end
    end
endmodule

// File: tb/tb_decim4x.sv
// tb_decim4x: directed self-checking bench for decim4x (WIDTH=18, 64-clock samples, 256-clock outputs).
module tb_decim4x;
    localparam int W = 18;
`ifdef DECIM4X_ROUND_EN
    localparam int R_P2 = 1, R_M2 = 0, R_3 = 1, R_M3 = -1, R_SHORT = 29;
`else
    localparam int R_P2 = 0, R_M2 = -1, R_3 = 0, R_M3 = -1, R_SHORT = 28;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                clkenin = 1'b0;
    logic                clkenout = 1'b0;
    logic signed [W-1:0] xkin = '0;
    logic signed [W-1:0] ykout;
    logic                ykvalid;
    logic                phaseerr;
    int                  n_chk = 0;
    int                  n_fail = 0;
    int                  prev = 0;

    always #5 clock = ~clock;

    decim4x #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .clkenin(clkenin), .clkenout(clkenout),
        .xkin(xkin), .ykout(ykout), .ykvalid(ykvalid), .phaseerr(phaseerr)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one strobe cycle and returns just after the edge that consumed it.
    task automatic sample(input int x, input logic co);
        @(negedge clock);
        clkenin  = 1'b1;
        clkenout = co;
        xkin     = W'(x);
        @(negedge clock);
        clkenin  = 1'b0;
        clkenout = 1'b0;
    endtask

    task automatic period(input int a, b, c, d, exp, err, input string tag);
        sample(a, 1'b0);
        chk({tag, "_hold"}, 32'(ykout), prev);
        idle(62);
        sample(b, 1'b0);
        idle(62);
        sample(c, 1'b0);
        idle(62);
        sample(d, 1'b1);
        chk({tag, "_ykout"}, 32'(ykout), exp);
        chk({tag, "_ykvalid"}, 32'(ykvalid), 1);
        chk({tag, "_phaseerr"}, 32'(phaseerr), err);
        @(negedge clock);
        chk({tag, "_ykvalid_low"}, 32'(ykvalid), 0);
        idle(61);
        prev = exp;
    endtask

    initial begin
        idle(3);
        clkenin  = 1'b1;
        clkenout = 1'b1;
        xkin     = W'(999);
        @(negedge clock);
        clkenin  = 1'b0;
        clkenout = 1'b0;
        chk("rst_ykout", 32'(ykout), 0);
        chk("rst_ykvalid", 32'(ykvalid), 0);
        chk("rst_phaseerr", 32'(phaseerr), 0);
        reset = 1'b1;
        idle(5);

        for (int i = 0; i < 3; i++) period(1000, 1000, 1000, 1000, 1000, 0, "const");
        period(0, 4, 8, 12, 6, 0, "ramp");
        period(131071, 131071, 131071, 131071, 131071, 0, "max");
        period(-131072, -131072, -131072, -131072, -131072, 0, "min");
        period(2, 0, 0, 0, R_P2, 0, "rnd_p2");
        period(-2, 0, 0, 0, R_M2, 0, "rnd_m2");
        period(1, 1, 1, 0, R_3, 0, "rnd_p3");
        period(-3, 0, 0, 0, R_M3, 0, "rnd_m3");
        period(100, 100, 100, 100, 100, 0, "pre_short");

        // Only three clkenin in this output period; window is 5+5+5+100.
        sample(5, 1'b0);
        chk("short_hold", 32'(ykout), prev);
        idle(62);
        sample(5, 1'b0);
        idle(62);
        sample(5, 1'b1);
        chk("short_ykout", 32'(ykout), R_SHORT);
        chk("short_ykvalid", 32'(ykvalid), 1);
        chk("short_phaseerr", 32'(phaseerr), 1);
        idle(62);
        prev = R_SHORT;
        for (int i = 0; i < 10; i++) period(1000, 1000, 1000, 1000, 1000, 1, "sticky");

        sample(7, 1'b0);
        idle(10);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ykout", 32'(ykout), 0);
        chk("midrst_ykvalid", 32'(ykvalid), 0);
        chk("midrst_phaseerr", 32'(phaseerr), 0);
        @(negedge clock);
        clkenin  = 1'b1;
        clkenout = 1'b1;
        xkin     = W'(55);
        @(negedge clock);
        clkenin  = 1'b0;
        clkenout = 1'b0;
        chk("midrst_ign_ykvalid", 32'(ykvalid), 0);
        chk("midrst_ign_ykout", 32'(ykout), 0);
        reset = 1'b1;
        idle(3);
        sample(400, 1'b1);
        chk("post_rst_ykout", 32'(ykout), 100);
        chk("post_rst_ykvalid", 32'(ykvalid), 1);
        chk("post_rst_phaseerr", 32'(phaseerr), 0);
        idle(62);
        prev = 100;
        period(100, 100, 100, 100, 100, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decim4x.md
DECIM4X -- requirements
Module: decim4x

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning sample width in bits (two's complement) for xkin and ykout.
REQ-002 SHALL have port clock  input  1  master clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clkenin  input  1  4xFs input clock enable (192 kHz); one-cycle pulse.
REQ-005 SHALL have port clkenout  input  1  Fs output clock enable (48 kHz); one-cycle pulse.
REQ-006 SHALL have port xkin  input  WIDTH  signed input sample, valid in cycles with clkenin=1.
REQ-007 SHALL have port ykout  output  WIDTH  signed decimated output sample, registered.
REQ-008 SHALL have port ykvalid  output  1  one-cycle pulse marking a new ykout.
REQ-009 SHALL have port phaseerr  output  1  sticky flag: clkenin/clkenout ratio violated.

Function
REQ-010 SHALL hold a 4-tap delay line d0..d3 (d0 newest); each clkenin=1 cycle shifts xkin into d0, d0->d1, d1->d2, d2->d3, and d3 is discarded.
REQ-011 SHALL compute sum S (WIDTH+2 bits, signed) = d0+d1+d2+d3 when clkenin=0; when clkenin=1 in the same cycle as clkenout=1, S = xkin+d0+d1+d2, so the sample arriving in that cycle is included.
REQ-012 SHALL, in a cycle with clkenout=1, load ykout with S scaled by 1/4 (per REQ-024/025); result always fits WIDTH bits, with no saturation logic required.
REQ-013 SHALL hold ykout unchanged in all cycles with clkenout=0.
REQ-014 SHALL assert ykvalid for exactly the one cycle following each cycle with clkenout=1, coincident with the new ykout value; latency from clkenout to ykout/ykvalid is 1 clock.
REQ-015 SHALL keep a 3-bit phase counter of clkenin pulses since the last clkenout, saturating at 7; the counter includes a clkenin coincident with clkenout, then restarts at 0 in the next cycle (or at 1 if clkenin is also high that cycle).
REQ-016 SHALL set phaseerr at a clkenout cycle when the counter value, including any coincident clkenin, is not 4; the first clkenout after reset is exempt.
REQ-017 SHALL keep phaseerr set until reset; it SHALL NOT gate or alter the data path.
REQ-018 SHALL treat back-to-back clkenout (consecutive cycles) as valid output events, each producing a ykvalid pulse and each subject to the REQ-016 check.
REQ-019 SHALL, before four samples have been received since reset, use zero for the unfilled taps; there is no special start-up state.

Reset
REQ-020 SHALL, on reset=0, asynchronously clear d0..d3, ykout, ykvalid, phaseerr, the phase counter and the first-output exemption flag to 0/initial.
REQ-021 SHALL, on reset asserted mid-operation, discard the partial accumulation; the first clkenout after release is exempt per REQ-016.
REQ-022 SHALL ignore clkenin and clkenout while reset=0.

Configuration
REQ-023 SHALL support macro DECIM4X_ROUND_EN, selecting the divide-by-4 mode.
REQ-024 SHALL, with DECIM4X_ROUND_EN defined, compute ykout = (S + 2) >>> 2 (round half up).
REQ-025 SHALL, without DECIM4X_ROUND_EN, compute ykout = S >>> 2 (truncate toward minus infinity).

Verification (WIDTH=18, clkenin every 64 clocks, clkenout every 256 clocks, aligned as in interpolator bench)
REQ-026 SHALL cover constant input: xkin=1000 for all samples -> from the 2nd output onward ykout=1000, phaseerr=0.
REQ-027 SHALL cover ramp and full scale: window {0,4,8,12} -> ykout=6; window all 131071 -> 131071; window all -131072 -> -131072.
REQ-028 SHALL cover rounding: window {2,0,0,0} -> ykout=1 with DECIM4X_ROUND_EN, 0 without; window {-2,0,0,0} -> 0 with, -1 without.
REQ-029 SHALL cover phase error: only 3 clkenin between two clkenout (after the first) -> phaseerr=1 one cycle later and still 1 after 10 further correct periods; ykout remains correct.
REQ-030 SHALL cover mid-operation reset: reset=0 during streaming -> ykout=0, ykvalid=0, phaseerr=0 immediately, without a clock edge; after release, the first output with 1 sample (coincident clkenin, xkin=400) -> ykout=100, no phaseerr.
